// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small input FIFO. Frame format (parity, stop bits,
// bit period) is latched when a word is popped and held for the whole frame.
module uart_tx_cfg #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          Data_Valid,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [PRESCALE_W-1:0]         PRESCALE,
  output logic                          TX_out,
  output logic                          busy,
  output logic                          ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned IW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         count_q, count_d;
  logic                  push, pop;

  // Frame state
  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  par_en_q, par_typ_q, stop2_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic                  tx_q, tx_d;
  logic                  busy_q, overflow_q;
  logic                  bit_end;

  // Full is judged on registered occupancy, so a same-edge pop never rescues a full write.
  assign ready   = (count_q != LW'(FIFO_DEPTH));
  assign push    = Data_Valid & ready;
  assign count_d = count_q + LW'(push) - LW'(pop);
  assign bit_end = (cnt_q == '0);
  assign word_d  = pop ? mem_q[rd_ptr_q] : word_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= P_DATA;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      pre_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      count_q    <= count_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != StIdle) || (count_d != '0);
      overflow_q <= Data_Valid & ~ready;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stop2_q   <= STOP2;
        pre_q     <= PRESCALE;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StStart;
          idx_d   = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IW'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? StParity : StStop;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          idx_d   = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          // idx counts stop bits already sent when two are configured
          if (stop2_q && (idx_q == '0)) begin
            idx_d = IW'(1);
          end else if (count_q != '0) begin
            pop     = 1'b1;
            state_d = StStart;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase

    cnt_d = cnt_q;
    if (pop) begin
      cnt_d = PRESCALE;
    end else if (state_d == StIdle) begin
      cnt_d = '0;
    end else if (bit_end) begin
      cnt_d = pre_q;
    end else begin
      cnt_d = cnt_q - PRESCALE_W'(1);
    end
  end

  // Output logic: line level for the upcoming cycle, registered in tx_q
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = word_d[idx_d];
      StParity: tx_d = (^word_q) ^ par_typ_q;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  assign TX_out     = tx_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: pushes words, queues the expected frames and checks the
// serial line cycle by cycle as each frame appears.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic [7:0] PRESCALE = 8'd3;
  logic       TX_out, busy, ready, overflow;
  logic [2:0] fifo_level;

  logic [4:0] d5_data = '0;
  logic       d5_valid = 1'b0;
  logic       tx5, busy5, ready5, ovf5;
  logic [2:0] lvl5;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic       s2;
    int         pre;
  } exp_t;

  exp_t exp_q[$];
  int   start_q[$];

  uart_tx_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESCALE_W(8)) u_dut (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE), .TX_out(TX_out), .busy(busy),
    .ready(ready), .overflow(overflow), .fifo_level(fifo_level)
  );

  uart_tx_cfg #(.DATA_WIDTH(5), .FIFO_DEPTH(4), .PRESCALE_W(8)) u_dut5 (
    .clk(clk), .rst(rst), .P_DATA(d5_data), .Data_Valid(d5_valid), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE), .TX_out(tx5), .busy(busy5),
    .ready(ready5), .overflow(ovf5), .fifo_level(lvl5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks,
             failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one write strobe for the next edge; acc says whether the FIFO should take it.
  task automatic push_word(input logic [7:0] w, input logic acc);
    exp_t e;
    @(negedge clk);
    check("ready_before_push", ready, acc);
    P_DATA     = w;
    Data_Valid = 1'b1;
    if (acc) begin
      e.d = w; e.pe = PAR_EN; e.pt = PAR_TYP; e.s2 = STOP2; e.pre = int'(PRESCALE);
      exp_q.push_back(e);
    end
  endtask

  task automatic release_valid();
    @(negedge clk);
    Data_Valid = 1'b0;
  endtask

  task automatic wait_idle(output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 2000);
    check("wait_idle", busy, 1'b0);
    at = cyc;
  endtask

  // Frame monitor: each falling start bit pops the next expected frame and checks every cycle.
  initial begin : monitor
    exp_t       e;
    logic [12:0] bits;
    int         nb;
    bit         ab;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && TX_out === 1'b0) begin
        start_q.push_back(cyc);
        check("frame_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          bits = '0;
          nb = 0;
          bits[nb] = 1'b0; nb = nb + 1;
          for (int i = 0; i < 8; i++) begin
            bits[nb] = e.d[i]; nb = nb + 1;
          end
          if (e.pe) begin
            bits[nb] = (^e.d) ^ e.pt; nb = nb + 1;
          end
          bits[nb] = 1'b1; nb = nb + 1;
          if (e.s2) begin
            bits[nb] = 1'b1; nb = nb + 1;
          end
          ab = 1'b0;
          for (int b = 0; b < nb && !ab; b++) begin
            for (int c = 0; c <= e.pre && !ab; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst !== 1'b1) ab = 1'b1;
              else check($sformatf("frame%0d_d%0h_bit%0d", start_q.size(), e.d, b), TX_out,
                         bits[b]);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int          n0, t, s, n;
    logic [6:0]  obs5, exp5;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", TX_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_overflow", overflow, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_no_frame", start_q.size(), 0);
    check("post_rst_tx", TX_out, 1'b1);

    // 0xA5, PRESCALE=3, no parity, one stop: 40-cycle frame
    PRESCALE = 8'd3;
    n0 = start_q.size();
    push_word(8'hA5, 1'b1);
    release_valid();
    check("busy_after_push", busy, 1'b1);
    wait_idle(t);
    check("a5_one_frame", start_q.size(), n0 + 1);
    if (start_q.size() > n0) check("a5_busy_fall", t - start_q[n0], 40);

    // Parity even/odd on 0x07
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    push_word(8'h07, 1'b1);
    release_valid();
    wait_idle(t);
    PAR_TYP = 1'b1;
    push_word(8'h07, 1'b1);
    release_valid();
    wait_idle(t);

    // Two stop bits, back-to-back frames
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1;
    n0 = start_q.size();
    push_word(8'h3C, 1'b1);
    push_word(8'hC3, 1'b1);
    release_valid();
    wait_idle(t);
    check("stop2_frames", start_q.size(), n0 + 2);
    if (start_q.size() > n0 + 1) check("stop2_gap", start_q[n0+1] - start_q[n0], 44);
    STOP2 = 1'b0;

    // Six writes into a 4-deep FIFO while idle: one dropped
    n0 = start_q.size();
    for (int i = 0; i < 6; i++) push_word(8'h10 + 8'(i), (i < 5));
    release_valid();
    check("ovf_pulse", overflow, 1'b1);
    check("ovf_level_full", fifo_level, 3'd4);
    @(negedge clk);
    check("ovf_one_cycle", overflow, 1'b0);
    wait_idle(t);
    check("burst_frames", start_q.size(), n0 + 5);
    if (start_q.size() >= n0 + 5)
      for (int i = 0; i < 4; i++)
        check($sformatf("burst_gap%0d", i), start_q[n0+i+1] - start_q[n0+i], 40);

    // Simultaneous push and pop at level 2
    PRESCALE = 8'd0;
    n0 = start_q.size();
    push_word(8'h11, 1'b1);
    push_word(8'h22, 1'b1);
    push_word(8'h33, 1'b1);
    release_valid();
    check("simul_level_pre", fifo_level, 3'd2);
    check("simul_started", start_q.size() > n0, 1'b1);
    if (start_q.size() > n0) begin
      s = start_q[n0];
      n = 0;
      while (cyc < s + 9 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("simul_level_before", fifo_level, 3'd2);
      P_DATA = 8'h44; Data_Valid = 1'b1;
      push_word_exp_only(8'h44);
      @(negedge clk);
      Data_Valid = 1'b0;
      check("simul_level_after", fifo_level, 3'd2);
    end
    wait_idle(t);
    check("simul_frames", start_q.size(), n0 + 4);

    // PRESCALE change mid-frame is ignored
    PRESCALE = 8'd1;
    n0 = start_q.size();
    push_word(8'h96, 1'b1);
    release_valid();
    repeat (6) @(negedge clk);
    PRESCALE = 8'd5;
    wait_idle(t);
    if (start_q.size() > n0) check("midpre_len", t - start_q[n0], 20);
    PRESCALE = 8'd3;

    // DATA_WIDTH=5, PRESCALE=0: 7-cycle frame, PRESCALE changed mid-frame
    @(negedge clk);
    PRESCALE = 8'd0;
    d5_data = 5'b10110; d5_valid = 1'b1;
    @(negedge clk);
    d5_valid = 1'b0;
    exp5[0] = 1'b0;
    for (int i = 0; i < 5; i++) exp5[i+1] = d5_data[i];
    exp5[6] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      obs5[k] = tx5;
      if (k == 1) PRESCALE = 8'd3;
    end
    check("dw5_frame", obs5, exp5);
    check("dw5_busy_last", busy5, 1'b1);
    @(negedge clk);
    check("dw5_busy_fall", busy5, 1'b0);
    check("dw5_idle_line", tx5, 1'b1);

    // Reset during DATA of the second of three queued frames
    PRESCALE = 8'd3;
    n0 = start_q.size();
    push_word(8'hA1, 1'b1);
    push_word(8'hB2, 1'b1);
    push_word(8'hC3, 1'b1);
    release_valid();
    n = 0;
    while (start_q.size() < n0 + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_second_started", start_q.size(), n0 + 2);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_tx", TX_out, 1'b1);
    check("rst_mid_level", fifo_level, 3'd0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ready", ready, 1'b1);
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (100) @(negedge clk);
    check("rst_mid_no_more", start_q.size(), n0 + 2);
    check("rst_mid_tx_idle", TX_out, 1'b1);
    check("rst_mid_busy_idle", busy, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic push_word_exp_only(input logic [7:0] w);
    exp_t e;
    e.d = w; e.pe = PAR_EN; e.pt = PAR_TYP; e.s2 = STOP2; e.pre = int'(PRESCALE);
    exp_q.push_back(e);
  endtask

endmodule
